// File: rtl/ddr3_axi_memtest.sv
// ---------------------------------------------------------------------------
// ddr3_axi_memtest
//
// AXI4 memory test initiator for the inport_* slave of the DDR3 AXI
// controller. It fills a contiguous region starting at BASE_ADDR with a
// deterministic pattern using NUM_BURSTS INCR bursts of BURST_LEN beats.
// It then reads the region back and compares every beat. When the run ends
// it reports pass/fail, a saturating error count and the first failing
// byte address.
//
// Only one burst is outstanding at any time. The whole write phase,
// including every write response, completes before the first read address
// is issued.
//
// Pattern selection (compile-time macro MEMTEST_LFSR_EN):
//   undefined : word = byte_addr ^ seed
//   defined   : word = 32-bit Galois LFSR (taps 32,22,2,1) seeded with seed
//               (a seed of 0 becomes 1). The LFSR steps once per write beat
//               and is reloaded from the seed when the read phase starts.
//
// Handshake semantics (every channel): a transfer happens on a rising clock
// edge where valid and ready are both high. A valid, once raised, stays
// high with a stable payload until that edge. awvalid and wvalid are never
// high together. bready is tied high. rready is high only while reading
// burst data.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   start_i, seed_i       start pulse (ignored while busy_o), pattern seed
//   busy_o, done_o        test running / test finished (held until restart)
//   pass_o                no mismatches and no error responses (with done_o)
//   err_count_o           saturating error count
//   first_err_addr_o      byte address of the first failing read beat
//   dbg_state_o           current FSM state encoding
//   outport_aw*/w*/b*     AXI write address / data / response channels
//   outport_ar*/r*        AXI read address / data channels
// ---------------------------------------------------------------------------
module ddr3_axi_memtest #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          NUM_BURSTS = 1024,
  parameter int          BURST_LEN  = 16,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [31:0] first_err_addr_o,
  output logic [2:0]  dbg_state_o,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  input  logic        outport_awready_i,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  input  logic        outport_wready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  output logic        outport_bready_o,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_arready_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_rready_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  state_e      state_q, state_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] burst_idx_q, burst_idx_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] burst_addr_q, burst_addr_d;   // first byte of the current burst
  logic [31:0] beat_addr_q, beat_addr_d;     // byte address of the current beat
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] first_err_addr_q, first_err_addr_d;
  logic        first_err_seen_q, first_err_seen_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;

  logic [1:0]  err_inc;
  logic        err_clear;
  logic        enter_done;
  logic        beat_bad;
  logic        short_burst;
  logic [31:0] next_burst_addr;
  logic [31:0] pattern;

`ifdef MEMTEST_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] lfsr_next;

  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
  assign pattern   = lfsr_q;
`else
  assign pattern   = beat_addr_q ^ seed_q;
`endif

  always_comb begin
    state_d          = state_q;
    seed_d           = seed_q;
    burst_idx_d      = burst_idx_q;
    beat_cnt_d       = beat_cnt_q;
    burst_addr_d     = burst_addr_q;
    beat_addr_d      = beat_addr_q;
    first_err_addr_d = first_err_addr_q;
    first_err_seen_d = first_err_seen_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    awvalid_d        = awvalid_q;
    wvalid_d         = wvalid_q;
    arvalid_d        = arvalid_q;
    rready_d         = rready_q;
    err_inc          = 2'd0;
    err_clear        = 1'b0;
    enter_done       = 1'b0;
    beat_bad         = 1'b0;
    short_burst      = 1'b0;
    next_burst_addr  = burst_addr_q + BURST_BYTES;
`ifdef MEMTEST_LFSR_EN
    lfsr_d           = lfsr_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (start_i) begin
          seed_d           = seed_i;
          burst_idx_d      = 16'd0;
          beat_cnt_d       = 8'd0;
          burst_addr_d     = BASE_ADDR;
          beat_addr_d      = BASE_ADDR;
          err_clear        = 1'b1;
          first_err_addr_d = 32'h0;
          first_err_seen_d = 1'b0;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          awvalid_d        = 1'b1;
          state_d          = ST_WR_ADDR;
`ifdef MEMTEST_LFSR_EN
          lfsr_d           = seed_fix(seed_i);
`endif
        end
      end

      ST_WR_ADDR: begin
        if (outport_awready_i) begin
          awvalid_d  = 1'b0;
          wvalid_d   = 1'b1;
          beat_cnt_d = 8'd0;
          state_d    = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        if (outport_wready_i) begin
          beat_addr_d = beat_addr_q + 32'd4;
`ifdef MEMTEST_LFSR_EN
          lfsr_d      = lfsr_next;
`endif
          if (beat_cnt_q == LAST_BEAT) begin
            wvalid_d = 1'b0;
            state_d  = ST_WR_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end

      ST_WR_RESP: begin
        if (outport_bvalid_i) begin
          err_inc = {1'b0, (outport_bresp_i != 2'b00) || (outport_bid_i != AXI_ID)};
          if (burst_idx_q == LAST_BURST) begin
            // Rewind address and pattern so the read phase replays the writes.
            burst_idx_d  = 16'd0;
            burst_addr_d = BASE_ADDR;
            beat_addr_d  = BASE_ADDR;
            arvalid_d    = 1'b1;
            state_d      = ST_RD_ADDR;
`ifdef MEMTEST_LFSR_EN
            lfsr_d       = seed_fix(seed_q);
`endif
          end else begin
            burst_idx_d  = burst_idx_q + 16'd1;
            burst_addr_d = next_burst_addr;
            beat_addr_d  = next_burst_addr;
            awvalid_d    = 1'b1;
            state_d      = ST_WR_ADDR;
          end
        end
      end

      ST_RD_ADDR: begin
        if (outport_arready_i) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          beat_cnt_d = 8'd0;
          state_d    = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (outport_rvalid_i) begin
          beat_bad    = (outport_rdata_i != pattern) || (outport_rresp_i != 2'b00) ||
                        (outport_rid_i != AXI_ID);
          // An early rlast is an extra error on top of any data error.
          short_burst = outport_rlast_i && (beat_cnt_q != LAST_BEAT);
          err_inc     = {1'b0, beat_bad} + {1'b0, short_burst};
          if ((beat_bad || short_burst) && !first_err_seen_q) begin
            first_err_seen_d = 1'b1;
            first_err_addr_d = beat_addr_q;
          end
          beat_addr_d = beat_addr_q + 32'd4;
          beat_cnt_d  = beat_cnt_q + 8'd1;
`ifdef MEMTEST_LFSR_EN
          // A short burst leaves the LFSR behind; later compares then fail
          // too, which is acceptable since the run is already failing.
          lfsr_d      = lfsr_next;
`endif
          if (outport_rlast_i) begin
            // Realign to the next burst even if the current one ended early.
            rready_d     = 1'b0;
            burst_addr_d = next_burst_addr;
            beat_addr_d  = next_burst_addr;
            if (burst_idx_q == LAST_BURST) begin
              busy_d     = 1'b0;
              done_d     = 1'b1;
              enter_done = 1'b1;
              state_d    = ST_DONE;
            end else begin
              burst_idx_d = burst_idx_q + 16'd1;
              arvalid_d   = 1'b1;
              state_d     = ST_RD_ADDR;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    err_count_d = err_clear ? 16'd0 : sat_add(err_count_q, err_inc);
    if (enter_done) pass_d = (err_count_d == 16'd0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q          <= ST_IDLE;
      seed_q           <= 32'h0;
      burst_idx_q      <= 16'd0;
      beat_cnt_q       <= 8'd0;
      burst_addr_q     <= 32'h0;
      beat_addr_q      <= 32'h0;
      err_count_q      <= 16'd0;
      first_err_addr_q <= 32'h0;
      first_err_seen_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      awvalid_q        <= 1'b0;
      wvalid_q         <= 1'b0;
      arvalid_q        <= 1'b0;
      rready_q         <= 1'b0;
`ifdef MEMTEST_LFSR_EN
      lfsr_q           <= 32'h1;
`endif
    end else begin
      state_q          <= state_d;
      seed_q           <= seed_d;
      burst_idx_q      <= burst_idx_d;
      beat_cnt_q       <= beat_cnt_d;
      burst_addr_q     <= burst_addr_d;
      beat_addr_q      <= beat_addr_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_seen_q <= first_err_seen_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      awvalid_q        <= awvalid_d;
      wvalid_q         <= wvalid_d;
      arvalid_q        <= arvalid_d;
      rready_q         <= rready_d;
`ifdef MEMTEST_LFSR_EN
      lfsr_q           <= lfsr_d;
`endif
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign err_count_o       = err_count_q;
  assign first_err_addr_o  = first_err_addr_q;
  assign dbg_state_o       = state_q;

  assign outport_awvalid_o = awvalid_q;
  assign outport_awaddr_o  = burst_addr_q;
  assign outport_awid_o    = AXI_ID;
  assign outport_awlen_o   = LAST_BEAT;
  assign outport_awburst_o = 2'b01;

  assign outport_wvalid_o  = wvalid_q;
  assign outport_wdata_o   = pattern;
  assign outport_wstrb_o   = 4'hF;
  assign outport_wlast_o   = wvalid_q && (beat_cnt_q == LAST_BEAT);

  assign outport_bready_o  = 1'b1;

  assign outport_arvalid_o = arvalid_q;
  assign outport_araddr_o  = burst_addr_q;
  assign outport_arid_o    = AXI_ID;
  assign outport_arlen_o   = LAST_BEAT;
  assign outport_arburst_o = 2'b01;

  assign outport_rready_o  = rready_q;

endmodule

// File: tb/tb_ddr3_axi_memtest.sv
// ---------------------------------------------------------------------------
// tb_ddr3_axi_memtest
//
// Directed sequence against ddr3_axi_memtest (BURST_LEN=4, NUM_BURSTS=2).
// A small AXI slave with a sparse word memory answers the DUT and can apply
// random backpressure, corrupt one word on read-back or return an error
// write response. Expected write data comes from a reference pattern
// function: address XOR seed, or the LFSR sequence when MEMTEST_LFSR_EN is
// defined. It is queued per run in exp_q.
// ---------------------------------------------------------------------------
module tb_ddr3_axi_memtest;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          NB    = 2;
  localparam int          BL    = 4;
  localparam int          BEATS = NB * BL;
`ifdef MEMTEST_LFSR_EN
  localparam logic [31:0] FIRST_WORD_SEED0 = 32'h1;
`else
  localparam logic [31:0] FIRST_WORD_SEED0 = 32'h0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst_n_i;
  logic        start_i;
  logic [31:0] seed_i;
  logic        busy_o, done_o, pass_o;
  logic [15:0] err_count_o;
  logic [31:0] first_err_addr_o;
  logic [2:0]  dbg_state_o;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, bresp, arburst, rresp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ddr3_axi_memtest #(
    .BASE_ADDR(BASE), .NUM_BURSTS(NB), .BURST_LEN(BL), .AXI_ID(4'd0)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .seed_i(seed_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
    .dbg_state_o(dbg_state_o),
    .outport_awvalid_o(awvalid), .outport_awaddr_o(awaddr), .outport_awid_o(awid),
    .outport_awlen_o(awlen), .outport_awburst_o(awburst), .outport_awready_i(awready),
    .outport_wvalid_o(wvalid), .outport_wdata_o(wdata), .outport_wstrb_o(wstrb),
    .outport_wlast_o(wlast), .outport_wready_i(wready),
    .outport_bvalid_i(bvalid), .outport_bresp_i(bresp), .outport_bid_i(bid),
    .outport_bready_o(bready),
    .outport_arvalid_o(arvalid), .outport_araddr_o(araddr), .outport_arid_o(arid),
    .outport_arlen_o(arlen), .outport_arburst_o(arburst), .outport_arready_i(arready),
    .outport_rvalid_i(rvalid), .outport_rdata_i(rdata), .outport_rresp_i(rresp),
    .outport_rid_i(rid), .outport_rlast_i(rlast), .outport_rready_o(rready)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference pattern for the k-th beat of a pass (beat k lives at BASE+4k).
  function automatic logic [31:0] exp_word(input int k, input logic [31:0] seed);
`ifdef MEMTEST_LFSR_EN
    logic [31:0] s;
    s = (seed == 32'h0) ? 32'h1 : seed;
    for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    return s;
`else
    return (BASE + 32'(4 * k)) ^ seed;
`endif
  endfunction

  // ---------------- AXI slave model ----------------
  bit          bp_en;
  bit          corrupt_en;
  logic [31:0] corrupt_addr;
  int          bresp_err_burst;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] aw_q[$];
  logic [31:0] ar_q[$];
  logic [1:0]  b_q[$];
  int          w_beat, r_beat, aw_cnt, ar_cnt, w_cnt, r_cnt, b_cnt;
  bit          b_fire_p, r_fire_p;
  bit          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic        p_wlast;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [31:0] first_wdata;

  function automatic logic rnd_ready();
    return bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic slave_clear();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rid = 4'd0; rlast = 1'b0;
    aw_q.delete(); ar_q.delete(); b_q.delete();
    w_beat = 0; r_beat = 0;
    b_fire_p = 1'b0; r_fire_p = 1'b0;
    p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0; p_arv = 1'b0; p_arr = 1'b0;
  endtask

  task automatic slave_step();
    logic [31:0] a, d, e;
    // Master-side stability across one clock edge without handshake.
    if (p_awv && !p_awr) begin
      chk("aw_valid_hold", awvalid, 1);
      chk("aw_addr_stable", awaddr, p_awaddr);
    end
    if (p_wv && !p_wr) begin
      chk("w_valid_hold", wvalid, 1);
      chk("w_data_stable", wdata, p_wdata);
      chk("w_last_stable", wlast, p_wlast);
    end
    if (p_arv && !p_arr) begin
      chk("ar_valid_hold", arvalid, 1);
      chk("ar_addr_stable", araddr, p_araddr);
    end
    if (wvalid) chk("aw_w_exclusive", awvalid, 0);

    // B: only responses queued on an earlier cycle are presented.
    if (b_fire_p) bvalid = 1'b0;
    if (!bvalid && b_q.size() > 0) begin
      bvalid = 1'b1;
      bresp  = b_q.pop_front();
      bid    = 4'd0;
    end
    b_fire_p = bvalid && bready;

    // R
    if (r_fire_p) begin
      rvalid = 1'b0;
      r_cnt++;
      if (r_beat == BL - 1) begin
        r_beat = 0;
        void'(ar_q.pop_front());
      end else begin
        r_beat++;
      end
    end
    if (!rvalid && ar_q.size() > 0 && rnd_ready()) begin
      a = ar_q[0] + 32'(4 * r_beat);
      d = mem.exists(a) ? mem[a] : 32'h0;
      if (corrupt_en && a == corrupt_addr) d = d ^ 32'h1;
      rvalid = 1'b1;
      rdata  = d;
      rlast  = (r_beat == BL - 1);
      rresp  = 2'b00;
      rid    = 4'd0;
    end
    r_fire_p = rvalid && rready;

    // AW
    awready = rnd_ready();
    if (awvalid && awready) begin
      chk("awaddr", awaddr, BASE + 32'(aw_cnt * BL * 4));
      chk("awlen", {24'h0, awlen}, 32'(BL - 1));
      chk("awburst", {30'h0, awburst}, 32'h1);
      chk("awid", {28'h0, awid}, 32'h0);
      aw_q.push_back(awaddr);
      aw_cnt++;
    end

    // W
    wready = rnd_ready();
    if (wvalid && wready) begin
      chk("w_after_aw", 32'(aw_q.size()), 32'h1);
      a = (aw_q.size() > 0) ? aw_q[0] + 32'(4 * w_beat) : 32'hFFFF_FFFC;
      mem[a] = wdata;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("wdata", wdata, e);
      chk("wlast", wlast, (w_beat == BL - 1));
      chk("wstrb", {28'h0, wstrb}, 32'hF);
      if (w_cnt == 0) first_wdata = wdata;
      w_cnt++;
      if (w_beat == BL - 1) begin
        w_beat = 0;
        if (aw_q.size() > 0) void'(aw_q.pop_front());
        b_q.push_back((b_cnt == bresp_err_burst) ? 2'b10 : 2'b00);
        b_cnt++;
      end else begin
        w_beat++;
      end
    end

    // AR
    arready = rnd_ready();
    if (arvalid && arready) begin
      chk("araddr", araddr, BASE + 32'(ar_cnt * BL * 4));
      chk("arlen", {24'h0, arlen}, 32'(BL - 1));
      chk("arburst", {30'h0, arburst}, 32'h1);
      chk("arid", {28'h0, arid}, 32'h0);
      ar_q.push_back(araddr);
      ar_cnt++;
    end

    p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
    p_wv  = wvalid;  p_wr  = wready;  p_wdata  = wdata; p_wlast = wlast;
    p_arv = arvalid; p_arr = arready; p_araddr = araddr;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (!rst_n_i) slave_clear();
      else slave_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic arm(input logic [31:0] seed);
    exp_q.delete();
    for (int k = 0; k < BEATS; k++) exp_q.push_back(exp_word(k, seed));
    aw_cnt = 0; ar_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    @(negedge clk); #1;
    seed_i  = seed;
    start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    chk("done_clear_after_start", done_o, 0);
  endtask

  task automatic run_test(input logic [31:0] seed);
    bit finished;
    arm(seed);
    finished = 1'b0;
    for (int c = 0; c < 2000 && !finished; c++) begin
      @(negedge clk); #1;
      if (done_o) finished = 1'b1;
    end
    chk("test_completes", finished, 1);
  endtask

  task automatic check_result(input logic exp_pass, input logic [15:0] exp_err);
    chk("done", done_o, 1);
    chk("busy_at_done", busy_o, 0);
    chk("pass", pass_o, exp_pass);
    chk("err_count", {16'h0, err_count_o}, {16'h0, exp_err});
    chk("aw_bursts", 32'(aw_cnt), 32'(NB));
    chk("ar_bursts", 32'(ar_cnt), 32'(NB));
    chk("w_beats", 32'(w_cnt), 32'(BEATS));
    chk("r_beats", 32'(r_cnt), 32'(BEATS));
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic check_reset_values();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_err_count", {16'h0, err_count_o}, 32'h0);
    chk("rst_first_err", first_err_addr_o, 32'h0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 1);
    chk("rst_state", {29'h0, dbg_state_o}, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit          hit;
    logic [31:0] s;
    rst_n_i = 1'b0; start_i = 1'b0; seed_i = 32'h0;
    bp_en = 1'b0; corrupt_en = 1'b0; corrupt_addr = 32'h0; bresp_err_burst = -1;
    first_wdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values();
    rst_n_i = 1'b1;

    // 1: ideal memory, seed 0
    run_test(32'h0);
    check_result(1'b1, 16'd0);
    chk("first_wdata_seed0", first_wdata, FIRST_WORD_SEED0);
    chk("mem_0x1c", mem.exists(32'h1C) ? mem[32'h1C] : 32'hFFFF_FFFF, exp_word(7, 32'h0));

    // 2: bit 0 of the word at 0x14 flipped on read-back
    corrupt_en = 1'b1; corrupt_addr = 32'h14;
    run_test(32'h0);
    check_result(1'b0, 16'd1);
    chk("first_err_addr", first_err_addr_o, 32'h14);
    corrupt_en = 1'b0;

    // 3: random backpressure, 32 passes x 2 bursts with random seeds
    bp_en = 1'b1;
    for (int t = 0; t < 32; t++) begin
      s = $urandom;
      run_test(s);
      check_result(1'b1, 16'd0);
    end
    bp_en = 1'b0;

    // 4: SLVERR on the first write burst; read phase still runs fully
    bresp_err_burst = 0;
    run_test(32'hA5A5_0001);
    check_result(1'b0, 16'd1);
    bresp_err_burst = -1;

    // 5: reset while beat 2 of the first write burst is on the bus
    s = 32'h1234_5678;
    arm(s);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk); #1;
      if (w_cnt == 2) hit = 1'b1;
    end
    chk("reach_wr_beat2", hit, 1);
    @(negedge clk); #1;
    chk("wr_beat2_valid", wvalid, 1);
    chk("wr_beat2_data", wdata, exp_word(2, s));
    rst_n_i = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    #1;
    rst_n_i = 1'b1;
    run_test(32'h0BAD_F00D);
    check_result(1'b1, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
